// File: rtl/gfx_clear_pkg.sv
// gfx_clear_pkg: shared types for the gfx frame-clear sequencer/arbiter.
// PASS forwards source beats, CLEAR emits the raster sweep, FLUSH waits
// for the final sweep beat to leave the output register.
package gfx_clear_pkg;

    typedef enum logic [1:0] {
        PASS  = 2'd0,
        CLEAR = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // True in the states where the arbiter owns the framebuffer port.
    function automatic logic is_busy_state(input state_t s);
        return (s == CLEAR) || (s == FLUSH);
    endfunction

endpackage

// File: rtl/gfx_clear_scan.sv
// gfx_clear_scan: row-major raster counter over the visible area.
// x counts first and wraps to 0 while y steps; last is combinational and
// marks the bottom-right pixel so the caller can stop on the final beat.
module gfx_clear_scan #(
    parameter int H_VISIBLE = 640,
    parameter int V_VISIBLE = 480,
    parameter int H_WIDTH   = 12,
    parameter int V_WIDTH   = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               adv,
    output logic [H_WIDTH-1:0] x,
    output logic [V_WIDTH-1:0] y,
    output logic               last
);

    localparam logic [H_WIDTH-1:0] X_LAST = H_WIDTH'(H_VISIBLE - 1);
    localparam logic [V_WIDTH-1:0] Y_LAST = V_WIDTH'(V_VISIBLE - 1);

    assign last = (x == X_LAST) && (y == Y_LAST);

    // Step the raster position, wrapping the whole frame after the last pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (clr) begin
            x <= '0;
            y <= '0;
        end else if (adv) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= (y == Y_LAST) ? '0 : y + V_WIDTH'(1);
            end else begin
                x <= x + H_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/gfx_clear_arb.sv
// gfx_clear_arb: frame-clear sequencer and arbiter in front of the
// framebuffer write port. Forwards source beats in PASS; on request it
// takes the port and sweeps CLEAR_PIXEL across the visible area, dropping
// source beats until the last sweep beat has been accepted downstream.
// Optional periodic auto-clear is enabled by defining GFX_CLEAR_AUTO_EN.
module gfx_clear_arb
    import gfx_clear_pkg::*;
#(
    parameter int                     H_WIDTH        = 12,
    parameter int                     V_WIDTH        = 12,
    parameter int                     PIXEL_WIDTH    = 12,
    parameter int                     H_VISIBLE      = 640,
    parameter int                     V_VISIBLE      = 480,
    parameter logic [PIXEL_WIDTH-1:0] CLEAR_PIXEL    = '0,
    parameter int                     CLEAR_INTERVAL = 1000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear_req,
    output logic                   clear_busy,
    output logic                   clear_done,
    input  logic                   s_gfx_valid,
    output logic                   s_gfx_ready,
    input  logic [H_WIDTH-1:0]     s_gfx_x,
    input  logic [V_WIDTH-1:0]     s_gfx_y,
    input  logic [PIXEL_WIDTH-1:0] s_gfx_pixel,
    output logic                   m_gfx_valid,
    input  logic                   m_gfx_ready,
    output logic [H_WIDTH-1:0]     m_gfx_x,
    output logic [V_WIDTH-1:0]     m_gfx_y,
    output logic [PIXEL_WIDTH-1:0] m_gfx_pixel
);

    state_t               state;
    logic                 pend;
    logic                 slot_free;
    logic                 auto_req;
    logic                 req_any;
    logic                 start_clear;
    logic                 out_handshake;
    logic                 scan_clr;
    logic                 scan_adv;
    logic                 scan_last;
    logic [H_WIDTH-1:0]   scan_x;
    logic [V_WIDTH-1:0]   scan_y;

    // The output register can take a new beat when empty or draining this cycle.
    assign slot_free     = !m_gfx_valid || m_gfx_ready;
    assign out_handshake = m_gfx_valid && m_gfx_ready;
    assign req_any       = clear_req || auto_req;
    assign start_clear   = (state == PASS) && (req_any || pend);
    assign scan_adv      = (state == CLEAR) && slot_free;
    assign scan_clr      = (state == FLUSH) && out_handshake;

    // Source sees backpressure only while forwarding; during a sweep it is drained.
    assign s_gfx_ready = is_busy_state(state) ? 1'b1 : slot_free;

    gfx_clear_scan #(
        .H_VISIBLE (H_VISIBLE),
        .V_VISIBLE (V_VISIBLE),
        .H_WIDTH   (H_WIDTH),
        .V_WIDTH   (V_WIDTH)
    ) u_scan (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (scan_clr),
        .adv   (scan_adv),
        .x     (scan_x),
        .y     (scan_y),
        .last  (scan_last)
    );

`ifdef GFX_CLEAR_AUTO_EN
    localparam int                 TIMER_W      = $clog2(CLEAR_INTERVAL + 1);
    localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(CLEAR_INTERVAL);

    logic [TIMER_W-1:0] auto_cnt;

    // Count down PASS cycles between automatic clears; restart on each sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_cnt <= TIMER_RELOAD;
        end else if (start_clear) begin
            auto_cnt <= TIMER_RELOAD;
        end else if ((state == PASS) && (auto_cnt != '0)) begin
            auto_cnt <= auto_cnt - TIMER_W'(1);
        end
    end

    assign auto_req = (state == PASS) && (auto_cnt == '0);
`else
    assign auto_req = 1'b0;
`endif

    // Sequencer: owns state, the collapsed follow-up request and the status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= PASS;
            pend       <= 1'b0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                PASS: begin
                    if (start_clear) begin
                        state      <= CLEAR;
                        pend       <= 1'b0;
                        clear_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (req_any) begin
                        pend <= 1'b1;
                    end
                    if (slot_free && scan_last) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (req_any) begin
                        pend <= 1'b1;
                    end
                    if (out_handshake) begin
                        state      <= PASS;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                    end
                end
                default: begin
                    state      <= PASS;
                    clear_busy <= 1'b0;
                end
            endcase
        end
    end

    // Output stage: loads a source beat, a sweep beat, or empties, only when free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_gfx_valid <= 1'b0;
            m_gfx_x     <= '0;
            m_gfx_y     <= '0;
            m_gfx_pixel <= '0;
        end else if (slot_free) begin
            case (state)
                PASS: begin
                    m_gfx_valid <= s_gfx_valid;
                    if (s_gfx_valid) begin
                        m_gfx_x     <= s_gfx_x;
                        m_gfx_y     <= s_gfx_y;
                        m_gfx_pixel <= s_gfx_pixel;
                    end
                end
                CLEAR: begin
                    m_gfx_valid <= 1'b1;
                    m_gfx_x     <= scan_x;
                    m_gfx_y     <= scan_y;
                    m_gfx_pixel <= CLEAR_PIXEL;
                end
                default: begin
                    m_gfx_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gfx_clear_arb.sv
// tb_gfx_clear_arb: self-checking bench for gfx_clear_arb with a 4x2
// visible area. A transaction-level model predicts every output cycle.
// Define GFX_CLEAR_AUTO_EN to also exercise the periodic auto-clear.
module tb_gfx_clear_arb;

    localparam int             HW  = 12;
    localparam int             VW  = 12;
    localparam int             PW  = 12;
    localparam int             HV  = 4;
    localparam int             VV  = 2;
    localparam int             CI  = 20;
    localparam logic [PW-1:0]  CPIX = 12'h000;

    typedef struct packed {
        logic [HW-1:0] x;
        logic [VW-1:0] y;
        logic [PW-1:0] p;
    } beat_t;

    logic          clk;
    logic          rst_n;
    logic          clear_req;
    logic          clear_busy;
    logic          clear_done;
    logic          s_gfx_valid;
    logic          s_gfx_ready;
    logic [HW-1:0] s_gfx_x;
    logic [VW-1:0] s_gfx_y;
    logic [PW-1:0] s_gfx_pixel;
    logic          m_gfx_valid;
    logic          m_gfx_ready;
    logic [HW-1:0] m_gfx_x;
    logic [VW-1:0] m_gfx_y;
    logic [PW-1:0] m_gfx_pixel;

    int errors = 0;
    int checks = 0;
    int doneCount = 0;
    int zeroBeats = 0;

    // Reference model state
    bit    mBusy;
    bit    mPend;
    bit    mDone;
    bit    mOutValid;
    beat_t mOut;
    beat_t mSweep[$];
    int    mTimer;

    gfx_clear_arb #(
        .H_WIDTH        (HW),
        .V_WIDTH        (VW),
        .PIXEL_WIDTH    (PW),
        .H_VISIBLE      (HV),
        .V_VISIBLE      (VV),
        .CLEAR_PIXEL    (CPIX),
        .CLEAR_INTERVAL (CI)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_req   (clear_req),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .s_gfx_valid (s_gfx_valid),
        .s_gfx_ready (s_gfx_ready),
        .s_gfx_x     (s_gfx_x),
        .s_gfx_y     (s_gfx_y),
        .s_gfx_pixel (s_gfx_pixel),
        .m_gfx_valid (m_gfx_valid),
        .m_gfx_ready (m_gfx_ready),
        .m_gfx_x     (m_gfx_x),
        .m_gfx_y     (m_gfx_y),
        .m_gfx_pixel (m_gfx_pixel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mBusy     = 1'b0;
        mPend     = 1'b0;
        mDone     = 1'b0;
        mOutValid = 1'b0;
        mOut      = '0;
        mSweep.delete();
        mTimer    = CI;
    endtask

    // Advance the model by one clock edge given this cycle's inputs.
    task automatic modelStep(input bit sv, input beat_t sb, input bit mr, input bit req);
        bit slotFree;
        bit startReq;
        bit nextDone;
        slotFree = !mOutValid || mr;
        nextDone = 1'b0;
        if (!mBusy) begin
            startReq = req || mPend;
`ifdef GFX_CLEAR_AUTO_EN
            if (mTimer == 0) startReq = 1'b1;
            if (startReq) mTimer = CI;
            else if (mTimer > 0) mTimer--;
`endif
            if (slotFree) begin
                mOutValid = sv;
                if (sv) mOut = sb;
            end
            if (startReq) begin
                mBusy = 1'b1;
                mPend = 1'b0;
                for (int yi = 0; yi < VV; yi++)
                    for (int xi = 0; xi < HV; xi++)
                        mSweep.push_back('{x: HW'(xi), y: VW'(yi), p: CPIX});
            end
        end else begin
            if (req) mPend = 1'b1;
            if (mSweep.size() > 0) begin
                if (slotFree) begin
                    mOut      = mSweep.pop_front();
                    mOutValid = 1'b1;
                end
            end else if (mOutValid && mr) begin
                mOutValid = 1'b0;
                mBusy     = 1'b0;
                nextDone  = 1'b1;
            end
        end
        mDone = nextDone;
    endtask

    // Drive one cycle, compare DUT against the model mid-cycle, then step the model.
    task automatic applyStimulus(input bit sv, input beat_t sb, input bit mr, input bit req);
        bit expReady;
        s_gfx_valid = sv;
        s_gfx_x     = sb.x;
        s_gfx_y     = sb.y;
        s_gfx_pixel = sb.p;
        m_gfx_ready = mr;
        clear_req   = req;
        @(negedge clk);
        checkOutput("m_valid", 32'(m_gfx_valid), 32'(mOutValid));
        if (mOutValid) begin
            checkOutput("m_x", 32'(m_gfx_x), 32'(mOut.x));
            checkOutput("m_y", 32'(m_gfx_y), 32'(mOut.y));
            checkOutput("m_pixel", 32'(m_gfx_pixel), 32'(mOut.p));
        end
        checkOutput("clear_busy", 32'(clear_busy), 32'(mBusy));
        checkOutput("clear_done", 32'(clear_done), 32'(mDone));
        expReady = mBusy ? 1'b1 : (!mOutValid || mr);
        checkOutput("s_ready", 32'(s_gfx_ready), 32'(expReady));
        if (clear_done === 1'b1) doneCount++;
        if (m_gfx_valid === 1'b1 && mr && m_gfx_pixel === CPIX) zeroBeats++;
        modelStep(sv, sb, mr, req);
        @(posedge clk);
        #1;
    endtask

    function automatic beat_t randBeat(input bit whitePixel);
        beat_t b;
        b.x = HW'($urandom);
        b.y = VW'($urandom);
        b.p = whitePixel ? 12'hFFF : PW'($urandom);
        return b;
    endfunction

    initial begin
        beat_t b;
        int d0;
        int z0;

        rst_n       = 1'b0;
        clear_req   = 1'b0;
        s_gfx_valid = 1'b0;
        s_gfx_x     = '0;
        s_gfx_y     = '0;
        s_gfx_pixel = '0;
        m_gfx_ready = 1'b1;
        modelReset();

        // Reset state
        #12;
        checkOutput("rst_m_valid", 32'(m_gfx_valid), 32'd0);
        checkOutput("rst_busy", 32'(clear_busy), 32'd0);
        checkOutput("rst_done", 32'(clear_done), 32'd0);
        checkOutput("rst_m_x", 32'(m_gfx_x), 32'd0);
        checkOutput("rst_m_y", 32'(m_gfx_y), 32'd0);
        checkOutput("rst_m_pixel", 32'(m_gfx_pixel), 32'd0);
        checkOutput("rst_s_ready", 32'(s_gfx_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed pass-through with one-cycle latency
        applyStimulus(1'b1, '{x: 12'd3, y: 12'd5, p: 12'hFFF}, 1'b1, 1'b0);
        checkOutput("pt_valid", 32'(m_gfx_valid), 32'd1);
        checkOutput("pt_x", 32'(m_gfx_x), 32'd3);
        checkOutput("pt_y", 32'(m_gfx_y), 32'd5);
        checkOutput("pt_pixel", 32'(m_gfx_pixel), 32'hFFF);

        // 100 random beats streamed in order
        for (int i = 0; i < 100; i++) applyStimulus(1'b1, randBeat(1'b0), 1'b1, 1'b0);

        // Backpressure: beat held stable for 5 cycles, then delivered
        applyStimulus(1'b1, randBeat(1'b0), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, randBeat(1'b0), 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Clear sweep while the source streams white pixels
        d0 = doneCount;
        z0 = zeroBeats;
        applyStimulus(1'b1, randBeat(1'b1), 1'b1, 1'b1);
        for (int i = 0; i < 14; i++) applyStimulus(1'b1, randBeat(1'b1), 1'b1, 1'b0);
        checkOutput("sweep_done_cnt", 32'(doneCount - d0), 32'd1);
        checkOutput("sweep_beats", 32'(zeroBeats - z0), 32'(HV * VV));

        // Random ready during a sweep with a beat stuck in the output at entry
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        d0 = doneCount;
        z0 = zeroBeats;
        applyStimulus(1'b1, randBeat(1'b1), 1'b0, 1'b0);
        applyStimulus(1'b1, randBeat(1'b1), 1'b0, 1'b1);
        for (int i = 0; i < 80; i++)
            applyStimulus(1'($urandom_range(0, 1)), randBeat(1'b1), 1'($urandom_range(0, 1)), 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("rnd_done_cnt", 32'(doneCount - d0), 32'd1);
        checkOutput("rnd_sweep_beats", 32'(zeroBeats - z0), 32'(HV * VV));

        // Two requests during a sweep collapse into one follow-up sweep
        d0 = doneCount;
        z0 = zeroBeats;
        applyStimulus(1'b1, randBeat(1'b1), 1'b1, 1'b1);
        for (int i = 0; i < 30; i++)
            applyStimulus(1'b1, randBeat(1'b1), 1'b1, (i == 2) || (i == 4));
        checkOutput("pend_done_cnt", 32'(doneCount - d0), 32'd2);
        checkOutput("pend_sweep_beats", 32'(zeroBeats - z0), 32'(2 * HV * VV));

        // Random mix of everything
        for (int i = 0; i < 200; i++)
            applyStimulus(1'($urandom_range(0, 1)), randBeat(1'b0), 1'($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 19) == 0));
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Reset asserted while sweep beat 3 is being presented
        d0 = doneCount;
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_m_valid", 32'(m_gfx_valid), 32'd0);
        checkOutput("abort_busy", 32'(clear_busy), 32'd0);
        checkOutput("abort_done", 32'(clear_done), 32'd0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 15; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
`ifndef GFX_CLEAR_AUTO_EN
        checkOutput("abort_no_done", 32'(doneCount - d0), 32'd0);
`endif

`ifdef GFX_CLEAR_AUTO_EN
        // Periodic auto-clear while idle
        d0 = doneCount;
        for (int i = 0; i < 120; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("auto_sweeps", 32'(doneCount - d0 >= 3), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
